// File: rtl/t2c_pose_tracker.sv
// t2c_pose_tracker: follows the maze explorer's move commands and keeps the
// bot's cell, heading, step/dead-end counts and exit/fault status.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | out of reset, waiting for the first valid command
//   RUN     | executing valid commands
//   DONE    | exit cell reached, commands ignored until rst
//   FAULT   | out-of-bounds move or illegal code, ignored until rst
module t2c_pose_tracker #(
    parameter int COLS    = 9,
    parameter int ROWS    = 9,
    parameter int START_X = 4,
    parameter int START_Y = 0,
    parameter int EXIT_X  = 4,
    parameter int EXIT_Y  = 8,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [2:0]       move,
    output logic [3:0]       pos_x,
    output logic [3:0]       pos_y,
    output logic [1:0]       heading,
    output logic [CNT_W-1:0] step_cnt,
    output logic [CNT_W-1:0] deadend_cnt,
    output logic             done,
    output logic             fault
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    localparam logic [2:0] M_STOP    = 3'd0;
    localparam logic [2:0] M_FORWARD = 3'd1;
    localparam logic [2:0] M_LEFT    = 3'd2;
    localparam logic [2:0] M_RIGHT   = 3'd3;
    localparam logic [2:0] M_UTURN   = 3'd4;

    localparam logic signed [4:0] COLS_S   = 5'(COLS);
    localparam logic signed [4:0] ROWS_S   = 5'(ROWS);
    localparam logic signed [4:0] EXIT_X_S = 5'(EXIT_X);
    localparam logic signed [4:0] EXIT_Y_S = 5'(EXIT_Y);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [1:0]        state;
    logic signed [4:0] dx, dy;
    logic signed [4:0] nx, ny;
    logic              in_bounds;
    logic              at_exit;
    logic              active;

    // Candidate next cell for a FORWARD; signed so that stepping off x=0 or
    // y=0 shows up as -1 rather than wrapping to 15.
    always_comb begin
        dx = 5'sd0;
        dy = 5'sd0;
        case (heading)
            2'd0:    dy = 5'sd1;
            2'd1:    dx = 5'sd1;
            2'd2:    dy = -5'sd1;
            default: dx = -5'sd1;
        endcase
        nx        = $signed({1'b0, pos_x}) + dx;
        ny        = $signed({1'b0, pos_y}) + dy;
        in_bounds = (nx >= 5'sd0) && (nx < COLS_S) && (ny >= 5'sd0) && (ny < ROWS_S);
        at_exit   = (nx == EXIT_X_S) && (ny == EXIT_Y_S);
        active    = cmd_valid && ((state == S_IDLE) || (state == S_RUN));
    end

    // Pose, counters and FSM update; rst wins over any command in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pos_x       <= 4'(START_X);
            pos_y       <= 4'(START_Y);
            heading     <= 2'd0;
            step_cnt    <= '0;
            deadend_cnt <= '0;
            done        <= 1'b0;
            fault       <= 1'b0;
        end else if (active) begin
            state <= S_RUN;
            case (move)
                M_STOP: ;
                M_LEFT:  heading <= heading - 2'd1;
                M_RIGHT: heading <= heading + 2'd1;
                M_UTURN: begin
                    heading <= heading + 2'd2;
                    if (deadend_cnt != CNT_MAX)
                        deadend_cnt <= deadend_cnt + 1'b1;
                end
                M_FORWARD: begin
                    if (in_bounds) begin
                        pos_x <= nx[3:0];
                        pos_y <= ny[3:0];
                        if (step_cnt != CNT_MAX)
                            step_cnt <= step_cnt + 1'b1;
                        if (at_exit) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end else begin
                        fault <= 1'b1;
                        state <= S_FAULT;
                    end
                end
                default: begin
                    fault <= 1'b1;
                    state <= S_FAULT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_t2c_pose_tracker.sv
// Bench for t2c_pose_tracker: a directed vector table, saturation sequences
// and a randomized run compared against a pose model.
module tb_t2c_pose_tracker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [2:0] move = 3'd0;
    logic [3:0] pos_x, pos_y;
    logic [1:0] heading;
    logic [7:0] step_cnt, deadend_cnt;
    logic       done, fault;

    int checks = 0;
    int errors = 0;

    t2c_pose_tracker dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .move(move),
        .pos_x(pos_x), .pos_y(pos_y), .heading(heading),
        .step_cnt(step_cnt), .deadend_cnt(deadend_cnt),
        .done(done), .fault(fault)
    );

    always #5 clk = ~clk;

    // Pose model: plain integers, one "ended" notion covering exit and fault.
    int m_x, m_y, m_h, m_step, m_dead;
    bit m_done, m_fault;

    task automatic model_step(input bit r, input bit v, input int m);
        int tx, ty;
        if (r) begin
            m_x = 4; m_y = 0; m_h = 0; m_step = 0; m_dead = 0;
            m_done = 0; m_fault = 0;
        end else if (v && !m_done && !m_fault) begin
            if (m == 2) m_h = (m_h + 3) % 4;
            else if (m == 3) m_h = (m_h + 1) % 4;
            else if (m == 4) begin
                m_h = (m_h + 2) % 4;
                m_dead = (m_dead < 255) ? m_dead + 1 : 255;
            end else if (m == 1) begin
                tx = m_x + ((m_h == 1) ? 1 : (m_h == 3) ? -1 : 0);
                ty = m_y + ((m_h == 0) ? 1 : (m_h == 2) ? -1 : 0);
                if (tx < 0 || tx > 8 || ty < 0 || ty > 8) m_fault = 1;
                else begin
                    m_x = tx; m_y = ty;
                    m_step = (m_step < 255) ? m_step + 1 : 255;
                    if (tx == 4 && ty == 8) m_done = 1;
                end
            end else if (m >= 5) m_fault = 1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs away from the edge; outputs settle by #1 after it.
    task automatic cyc(input bit r, input bit v, input int m);
        rst = r; cmd_valid = v; move = 3'(m);
        @(posedge clk);
        #1;
        model_step(r, v, m);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".x"}, 32'(pos_x), 32'(m_x));
        chk({tag, ".y"}, 32'(pos_y), 32'(m_y));
        chk({tag, ".h"}, 32'(heading), 32'(m_h));
        chk({tag, ".step"}, 32'(step_cnt), 32'(m_step));
        chk({tag, ".dead"}, 32'(deadend_cnt), 32'(m_dead));
        chk({tag, ".done"}, 32'(done), 32'(m_done));
        chk({tag, ".fault"}, 32'(fault), 32'(m_fault));
    endtask

    typedef struct {
        bit r; bit v; int m;
        int ex, ey, eh, es, ed;
        bit edone, efault;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit r, bit v, int m, int ex, int ey, int eh,
                                int es, int ed, bit edn, bit ef);
        vec_t t;
        t.r = r; t.v = v; t.m = m; t.ex = ex; t.ey = ey; t.eh = eh;
        t.es = es; t.ed = ed; t.edone = edn; t.efault = ef;
        return t;
    endfunction

    initial begin
        // reset held 2 cycles with a FORWARD pending
        tbl.push_back(mk(1,1,1, 4,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,1, 4,0,0,0,0,0,0));
        // straight north to the exit
        for (int i = 1; i <= 8; i++)
            tbl.push_back(mk(0,1,1, 4,i,0,i,0, i == 8, 0));
        tbl.push_back(mk(0,1,1, 4,8,0,8,0,1,0));
        tbl.push_back(mk(0,1,4, 4,8,0,8,0,1,0));
        // turn-and-step with a cmd_valid=0 gap
        tbl.push_back(mk(1,0,0, 4,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,3, 4,0,1,0,0,0,0));
        tbl.push_back(mk(0,1,1, 5,0,1,1,0,0,0));
        tbl.push_back(mk(0,1,2, 5,0,0,1,0,0,0));
        tbl.push_back(mk(0,0,1, 5,0,0,1,0,0,0));
        tbl.push_back(mk(0,1,1, 5,1,0,2,0,0,0));
        // west wall
        tbl.push_back(mk(1,0,0, 4,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,2, 4,0,3,0,0,0,0));
        for (int i = 1; i <= 4; i++)
            tbl.push_back(mk(0,1,1, 4-i,0,3,i,0,0,0));
        tbl.push_back(mk(0,1,1, 0,0,3,4,0,0,1));
        tbl.push_back(mk(0,1,3, 0,0,3,4,0,0,1));
        tbl.push_back(mk(0,1,7, 0,0,3,4,0,0,1));
        // U_TURN then step off the south edge
        tbl.push_back(mk(1,0,0, 4,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,4, 4,0,2,0,1,0,0));
        tbl.push_back(mk(0,1,1, 4,0,2,0,1,0,1));
        // illegal code
        tbl.push_back(mk(1,0,0, 4,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,6, 4,0,0,0,0,0,1));
        // reset coincident with a command, then IDLE accepts again
        tbl.push_back(mk(1,0,0, 4,0,0,0,0,0,0));
        for (int i = 1; i <= 3; i++)
            tbl.push_back(mk(0,1,1, 4,i,0,i,0,0,0));
        tbl.push_back(mk(1,1,1, 4,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,1, 4,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,3, 4,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,1, 4,1,0,1,0,0,0));

        foreach (tbl[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            cyc(tbl[i].r, tbl[i].v, tbl[i].m);
            chk({tag, ".x"}, 32'(pos_x), 32'(tbl[i].ex));
            chk({tag, ".y"}, 32'(pos_y), 32'(tbl[i].ey));
            chk({tag, ".h"}, 32'(heading), 32'(tbl[i].eh));
            chk({tag, ".step"}, 32'(step_cnt), 32'(tbl[i].es));
            chk({tag, ".dead"}, 32'(deadend_cnt), 32'(tbl[i].ed));
            chk({tag, ".done"}, 32'(done), 32'(tbl[i].edone));
            chk({tag, ".fault"}, 32'(fault), 32'(tbl[i].efault));
        end

        // dead-end counter saturation; heading keeps rotating
        cyc(1, 0, 0);
        for (int i = 0; i < 256; i++) cyc(0, 1, 4);
        chk("dead_sat", 32'(deadend_cnt), 32'd255);
        chk("dead_sat.h", 32'(heading), 32'd0);
        cyc(0, 1, 4);
        chk("dead_sat2", 32'(deadend_cnt), 32'd255);
        chk("dead_sat2.h", 32'(heading), 32'd2);

        // step counter saturation by shuttling east/west between x=4 and x=5
        cyc(1, 0, 0);
        cyc(0, 1, 3);
        for (int i = 0; i < 300; i++) begin
            cyc(0, 1, 1);
            cyc(0, 1, 4);
        end
        chk("step_sat", 32'(step_cnt), 32'd255);
        chk("step_sat.fault", 32'(fault), 32'd0);
        chk_model("step_sat");

        // randomized walk against the model
        cyc(1, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            bit r, v;
            int m;
            r = ($urandom_range(0, 39) == 0);
            v = ($urandom_range(0, 3) != 0);
            m = ($urandom_range(0, 49) == 0) ? $urandom_range(5, 7)
              : (($urandom_range(0, 1) == 0) ? 1 : $urandom_range(0, 4));
            cyc(r, v, m);
            chk_model($sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
